// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------------------------
// alu_operand_stage
//
// Issue stage in front of the 32-bit adder/subtractor. Decodes RV32I opcode/funct3/funct7b5
// into operand selects and the arithmetic-unit controls {s1, s0, bneg}, then registers them in
// a two-entry (main + skid) valid/ready pipeline stage with a synchronous flush.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid / in_ready      upstream handshake; in_ready is a flop output (skid empty)
//   in_opcode, in_funct3,    decoded instruction fields
//   in_funct7b5
//   in_pc, in_rs1, in_rs2,   operand sources
//   in_imm
//   flush                    drop both held entries and any input this cycle
//   out_valid / out_ready    downstream handshake
//   out_a, out_b             arithmetic-unit operands (B is not inverted here)
//   out_s1, out_s0, out_bneg arithmetic-unit controls
//   out_illegal              instruction cannot be executed by the arithmetic unit
// ---------------------------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic            out_s1,
    output logic            out_s0,
    output logic            out_bneg,
    output logic            out_illegal
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;
    localparam logic [6:0] OpcAuipc = 7'b0010111;
    localparam logic [6:0] OpcLui   = 7'b0110111;

    // {s1, s0, bneg}
    localparam logic [2:0] CtlAdd  = 3'b000;
    localparam logic [2:0] CtlSub  = 3'b001;
    localparam logic [2:0] CtlSlt  = 3'b011;
    localparam logic [2:0] CtlSltu = 3'b101;

    // Payload layout: {illegal, s1, s0, bneg, b, a}
    localparam int unsigned PW = 2 * XLEN + 4;

    // ---------------------------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------------------------
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [2:0]      w_ctl;
    logic            w_illegal;
    logic [PW-1:0]   w_payload;

    always_comb begin
        w_a       = in_rs1;
        w_b       = in_rs2;
        w_ctl     = CtlAdd;
        w_illegal = 1'b0;
        case (in_opcode)
            OpcOp: begin
                case (in_funct3)
                    3'b000:  w_ctl = in_funct7b5 ? CtlSub : CtlAdd;
                    3'b010:  w_ctl = CtlSlt;
                    3'b011:  w_ctl = CtlSltu;
                    default: w_illegal = 1'b1;
                endcase
            end
            OpcOpImm: begin
                // funct7b5 is ignored here; SRAI is not handled by this unit anyway.
                case (in_funct3)
                    3'b000: begin
                        w_b   = in_imm;
                        w_ctl = CtlAdd;
                    end
                    3'b010: begin
                        w_b   = in_imm;
                        w_ctl = CtlSlt;
                    end
                    3'b011: begin
                        w_b   = in_imm;
                        w_ctl = CtlSltu;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OpcLoad, OpcStore: begin
                w_b = in_imm;
            end
            OpcAuipc: begin
                w_a = in_pc;
                w_b = in_imm;
            end
            OpcLui: begin
                w_a = '0;
                w_b = in_imm;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_payload = {w_illegal, w_ctl, w_b, w_a};

    // ---------------------------------------------------------------------------------------
    // Main + skid registers
    // ---------------------------------------------------------------------------------------
    logic          r_main_valid;
    logic          r_skid_valid;
    logic          r_in_ready;
    logic [PW-1:0] r_main;
    logic [PW-1:0] r_skid;

    logic w_in_fire;
    logic w_main_free;

    assign w_in_fire   = in_valid & r_in_ready;
    // Main can take new data if empty or being consumed this cycle.
    assign w_main_free = ~r_main_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            // Data is left as-is; only the valid bits matter.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid) begin
            // in_ready is low, so nothing is accepted while the skid is occupied.
            if (w_main_free) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (w_in_fire) begin
            if (w_main_free) begin
                r_main       <= w_payload;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_payload;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end
        end else if (r_main_valid && out_ready) begin
            r_main_valid <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign out_a       = r_main[XLEN-1:0];
    assign out_b       = r_main[2*XLEN-1:XLEN];
    assign out_bneg    = r_main[2*XLEN];
    assign out_s0      = r_main[2*XLEN+1];
    assign out_s1      = r_main[2*XLEN+2];
    assign out_illegal = r_main[2*XLEN+3];

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 32-bit arithmetic unit (adder/subtractor with SLT/SLTU select).
- Accepts decoded RV32I instruction fields and register-file operands.
- Selects operand A/B, decodes the arithmetic-unit controls (s1, s0, Bneg) and registers them in a 2-entry skid-buffered pipeline stage with valid/ready handshake and flush.
- Output feeds the arithmetic unit's A, B, s1, s0, Bneg inputs without further logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  7  instr[6:0].
- in_funct3  input  3  instr[14:12].
- in_funct7b5  input  1  instr[30].
- in_pc  input  32  instruction PC.
- in_rs1  input  32  rs1 value.
- in_rs2  input  32  rs2 value.
- in_imm  input  32  sign-extended immediate, already formatted by the decoder.
- flush  input  1  kill all held and incoming instructions.
- out_valid  output  1  registered A/B/controls are valid.
- out_ready  input  1  downstream consumes this cycle.
- out_a  output  32  arithmetic unit A.
- out_b  output  32  arithmetic unit B (un-inverted; the unit applies Bneg).
- out_s1, out_s0, out_bneg  output  1 each  arithmetic unit controls.
- out_illegal  output  1  opcode/funct3 not executable by the arithmetic unit.

Behaviour:

Decode (combinational, applied on input side):
- OP 0110011, f3 000: A=rs1, B=rs2; funct7b5=0 → ADD {s1,s0,bneg}=000; funct7b5=1 → SUB 001.
- OP f3 010 SLT → 011; f3 011 SLTU → 101; A=rs1, B=rs2.
- OP-IMM 0010011: f3 000 ADDI → 000; 010 SLTI → 011; 011 SLTIU → 101. A=rs1, B=imm. funct7b5 ignored.
- LOAD 0000011 / STORE 0100011: address add; A=rs1, B=imm, 000.
- AUIPC 0010111: A=pc, B=imm, 000.
- LUI 0110111: A=0, B=imm, 000.
- Any other opcode/funct3: A=rs1, B=rs2, 000, out_illegal=1. Otherwise out_illegal=0.

Pipeline:
- One main output register plus one skid register.
- in_ready is registered: in_ready = skid empty.
- Transfer occurs on in_valid & in_ready (input) and on out_valid & out_ready (output).
- Latency: an accepted instruction appears on out_* the next cycle if the main register is empty or draining that cycle; otherwise it goes to skid.
- Main empty or draining and skid empty: input loads main.
- Main full, not draining, input accepted: input loads skid; in_ready falls next cycle.
- Main draining while skid full: skid moves to main, skid empties, in_ready rises next cycle. No input is accepted that cycle (in_ready=0).
- Outputs hold stable while out_valid & ~out_ready.
- Full throughput with out_ready held high: one instruction per cycle, no bubbles.

Flush:
- Synchronous; both entries invalidated at the clock edge.
- Any input presented that cycle is dropped, even if in_valid & in_ready.
- The cycle after flush: out_valid=0, in_ready=1.
- Flush has priority over every other event.

Reset:
- Every clock edge with rst=1 gives out_valid=0, in_ready=1.
- out_a=0, out_b=0, out_s1=0, out_s0=0, out_bneg=0, out_illegal=0; skid cleared.
- Reset mid-transfer discards all held instructions.
- Data registers are only updated on load; they are not cleared by flush.

Test Plan:
- ADD/SUB/SLT/SLTU: OP with rs1=5, rs2=7, f3 000/000(b5=1)/010/011, out_ready=1 → next cycle out_valid=1, A=5, B=7, controls 000/001/011/101.
- Immediate forms: AUIPC pc=0x1000, imm=0x2000 → A=0x1000, B=0x2000, 000. LUI imm=0xABCDE000 → A=0, B=0xABCDE000. SLTIU rs1=3, imm=0xFFFFFFFF → A=3, B=0xFFFFFFFF, 101. AND (OP f3 111) → out_illegal=1.
- Backpressure: stream 4 ADDIs with imm 1..4 while out_ready=0 → first in main, second in skid, in_ready=0 from cycle 3. Release out_ready → outputs 1,2,3,4 in order, none lost or duplicated.
- Throughput: out_ready=1, in_valid=1 for 16 cycles → 16 consecutive out_valid cycles, in_ready never drops.
- Flush with both entries full plus a valid input → next cycle out_valid=0, in_ready=1. The next accepted instruction is the first output.
- Reset asserted for 1 cycle while skid full → out_valid=0, in_ready=1, all out_* zero. Normal operation resumes the following cycle.
